// File: rtl/dac_seq_pkg.sv
// Shared definitions for the DAC sample sequencer: sample width and FSM state encoding.
package dac_seq_pkg;
    localparam int DAC_BITS = 10;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_RUN
    } dac_seq_state_t;
endpackage

// File: rtl/dac_sample_fifo.sv
// Sample FIFO for the DAC sequencer. Flush beats push/pop, and a push is accepted
// at full when a pop happens in the same cycle. Full/empty are registered.
module dac_sample_fifo
    import dac_seq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = DAC_BITS
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic [WIDTH-1:0]       head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    always_comb begin
        do_pop   = pop && !empty_q && !flush;
        do_push  = push && (!full_q || do_pop) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      level_d = level_q + (AW+1)'(1);
            else if (!do_push && do_pop) level_d = level_q - (AW+1)'(1);
        end
        full_d  = (level_d == FULL_LEVEL);
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: only slots between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;
    assign head  = mem_q[rd_ptr_q];
endmodule

// File: rtl/dac_sequencer.sv
// DAC sample sequencer: power-up settle, programmable sample rate, sticky underflow.
// Optional threshold interrupt is built when DAC_SEQ_IRQ_EN is defined.
module dac_sequencer
    import dac_seq_pkg::*;
#(
    parameter int DEPTH         = 8,
    parameter int SETTLE_CYCLES = 64,
    parameter int DIV_W         = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cfg_en,
    input  logic [DIV_W-1:0]       cfg_div,
    input  logic                   cfg_flush,
    input  logic                   ufl_clr,
    input  logic                   wr_valid,
    input  logic [DAC_BITS-1:0]    wr_data,
    output logic                   wr_ready,
    output logic [DAC_BITS-1:0]    dac_d,
    output logic                   dac_en,
    output logic [$clog2(DEPTH):0] level,
    output logic                   busy,
`ifdef DAC_SEQ_IRQ_EN
    input  logic [$clog2(DEPTH):0] irq_thresh,
    output logic                   irq,
`endif
    output logic                   underflow
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    dac_seq_state_t        state_q, state_d;
    logic [SW-1:0]         settle_q, settle_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic                  first_q, first_d;
    logic [DAC_BITS-1:0]   dac_d_q, dac_d_d;
    logic                  dac_en_q, dac_en_d;
    logic                  underflow_q, underflow_d;
    logic                  busy_q, busy_d;
    logic                  tick;
    logic                  fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_level;
    logic [DAC_BITS-1:0]   fifo_head;

    dac_sample_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DAC_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (wr_valid),
        .pop     (tick),
        .flush   (cfg_flush),
        .wr_data (wr_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level),
        .head    (fifo_head)
    );

    // first_q forces a tick in the first RUN cycle so the first sample leaves without a full period.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        div_d       = '0;
        first_d     = 1'b0;
        dac_d_d     = dac_d_q;
        dac_en_d    = dac_en_q;
        tick        = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                dac_en_d = 1'b0;
                dac_d_d  = '0;
                settle_d = '0;
                if (cfg_en) begin
                    state_d  = ST_SETTLE;
                    settle_d = SETTLE_LOAD;
                    dac_en_d = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (!cfg_en) begin
                    state_d  = ST_IDLE;
                    settle_d = '0;
                    dac_en_d = 1'b0;
                    dac_d_d  = '0;
                end else if (settle_q == '0) begin
                    state_d = ST_RUN;
                    first_d = 1'b1;
                end else begin
                    settle_d = settle_q - SW'(1);
                end
            end
            ST_RUN: begin
                if (!cfg_en) begin
                    state_d  = ST_IDLE;
                    dac_en_d = 1'b0;
                    dac_d_d  = '0;
                end else begin
                    tick  = first_q || (div_q >= cfg_div);
                    div_d = tick ? '0 : div_q + DIV_W'(1);
                    if (tick && !fifo_empty && !cfg_flush) dac_d_d = fifo_head;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        underflow_d = underflow_q;
        if (tick && fifo_empty) underflow_d = 1'b1;
        else if (ufl_clr)       underflow_d = 1'b0;

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            settle_q    <= '0;
            div_q       <= '0;
            first_q     <= 1'b0;
            dac_d_q     <= '0;
            dac_en_q    <= 1'b0;
            underflow_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            div_q       <= div_d;
            first_q     <= first_d;
            dac_d_q     <= dac_d_d;
            dac_en_q    <= dac_en_d;
            underflow_q <= underflow_d;
            busy_q      <= busy_d;
        end
    end

`ifdef DAC_SEQ_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = (state_q == ST_RUN) && ((fifo_level <= irq_thresh) || underflow_q);
    end

    always_ff @(posedge clk) begin
        if (reset) irq_q <= 1'b0;
        else       irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

    assign wr_ready  = !fifo_full;
    assign dac_d     = dac_d_q;
    assign dac_en    = dac_en_q;
    assign level     = fifo_level;
    assign busy      = busy_q;
    assign underflow = underflow_q;
endmodule
